// File: rtl/fetch_sequencer.sv
// Instruction-fetch and run-control sequencer: IDLE/RUN/DONE control, writable branch-target
// table (absolute or PC-relative targets), stall handling and saturating run counters.
module fetch_sequencer #(
    parameter int unsigned PW = 12,
    parameter int unsigned LW = 6,
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] BootAddr,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [LW-1:0] TargSel,
    input  logic          LutWe,
    input  logic [LW-1:0] LutWaddr,
    input  logic [PW-1:0] LutWdata,
    output logic [PW-1:0] PrgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCt,
    output logic [CW-1:0] InstCt
);

    localparam int unsigned Depth = 2 ** LW;
    localparam logic [PW-1:0] PcOne = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        state;
    logic [PW-1:0] lut [Depth];
    logic [PW-1:0] targ;
    logic [PW-1:0] pc_next;
    logic [CW-1:0] cycle_sat;
    logic [CW-1:0] inst_sat;

    // Combinational table read: a same-cycle write is only seen on the following cycle.
    assign targ = lut[TargSel];

    always_comb begin
        pc_next = PrgCtr + PcOne;
        if (BranchEn) begin
            // Relative entries are two's complement; the PW-bit add wraps naturally.
            pc_next = BranchRel ? (PrgCtr + targ) : targ;
        end
    end

    always_comb begin
        cycle_sat = (CycleCt == CntMax) ? CycleCt : CycleCt + CntOne;
        inst_sat  = (InstCt == CntMax) ? InstCt : InstCt + CntOne;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= StIdle;
            PrgCtr  <= '0;
            Running <= 1'b0;
            Done    <= 1'b0;
            CycleCt <= '0;
            InstCt  <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (Start) begin
                        state   <= StRun;
                        Running <= 1'b1;
                        Done    <= 1'b0;
                        PrgCtr  <= BootAddr;
                        CycleCt <= '0;
                        InstCt  <= '0;
                    end
                end
                StRun: begin
                    CycleCt <= cycle_sat;
                    if (!Stall) begin
                        InstCt <= inst_sat;
                        if (Halt) begin
                            state   <= StDone;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                        end else begin
                            PrgCtr <= pc_next;
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) begin
                lut[i] <= '0;
            end
        end else if (LutWe) begin
            lut[LutWaddr] <= LutWdata;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised bench for fetch_sequencer against a behavioural model, with directed scenarios
// pinned by literal expectations; a second instance uses narrow counters to exercise saturation.
module tb_fetch_sequencer;

    localparam int unsigned PW = 12;
    localparam int unsigned LW = 6;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [PW-1:0] BootAddr;
    logic          Stall;
    logic          Halt;
    logic          BranchEn;
    logic          BranchRel;
    logic [LW-1:0] TargSel;
    logic          LutWe;
    logic [LW-1:0] LutWaddr;
    logic [PW-1:0] LutWdata;

    logic [PW-1:0] pc_a, pc_b;
    logic          run_a, run_b, done_a, done_b;
    logic [15:0]   cyc_a, inst_a;
    logic [3:0]    cyc_b, inst_b;

    int tests = 0;
    int fails = 0;

    // Model state: 0 = idle, 1 = run, 2 = done; counters held as plain integers.
    int m_state;
    int m_pc;
    int m_cyc;
    int m_inst;
    int m_tab [64];
    bit m_valid = 1'b0;

    fetch_sequencer #(.PW(PW), .LW(LW), .CW(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BootAddr(BootAddr), .Stall(Stall),
        .Halt(Halt), .BranchEn(BranchEn), .BranchRel(BranchRel), .TargSel(TargSel),
        .LutWe(LutWe), .LutWaddr(LutWaddr), .LutWdata(LutWdata), .PrgCtr(pc_a),
        .Running(run_a), .Done(done_a), .CycleCt(cyc_a), .InstCt(inst_a)
    );

    fetch_sequencer #(.PW(PW), .LW(LW), .CW(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BootAddr(BootAddr), .Stall(Stall),
        .Halt(Halt), .BranchEn(BranchEn), .BranchRel(BranchRel), .TargSel(TargSel),
        .LutWe(LutWe), .LutWaddr(LutWaddr), .LutWdata(LutWdata), .PrgCtr(pc_b),
        .Running(run_b), .Done(done_b), .CycleCt(cyc_b), .InstCt(inst_b)
    );

    initial forever #5 Clk = ~Clk;

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step();
        if (Reset) begin
            m_state = 0;
            m_pc    = 0;
            m_cyc   = 0;
            m_inst  = 0;
            for (int i = 0; i < 64; i++) m_tab[i] = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        if (m_state != 1) begin
            if (Start) begin
                m_state = 1;
                m_pc    = int'(BootAddr);
                m_cyc   = 0;
                m_inst  = 0;
            end
        end else begin
            m_cyc = sat(m_cyc + 1, 65535);
            if (!Stall) begin
                m_inst = sat(m_inst + 1, 65535);
                if (Halt) m_state = 2;
                else if (BranchEn && BranchRel) m_pc = (m_pc + m_tab[TargSel]) % 4096;
                else if (BranchEn) m_pc = m_tab[TargSel];
                else m_pc = (m_pc + 1) % 4096;
            end
        end
        if (LutWe) m_tab[LutWaddr] = int'(LutWdata);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input int act, input int mdl, input int want);
        chk(name, act, want);
        chk({name, "_model"}, mdl, want);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    initial forever begin
        @(negedge Clk);
        if (m_valid) begin
            chk("pc_a", int'(pc_a), m_pc);
            chk("run_a", int'(run_a), int'(m_state == 1));
            chk("done_a", int'(done_a), int'(m_state == 2));
            chk("cyc_a", int'(cyc_a), m_cyc);
            chk("inst_a", int'(inst_a), m_inst);
            chk("pc_b", int'(pc_b), m_pc);
            chk("run_b", int'(run_b), int'(m_state == 1));
            chk("done_b", int'(done_b), int'(m_state == 2));
            chk("cyc_b", int'(cyc_b), sat(m_cyc, 15));
            chk("inst_b", int'(inst_b), sat(m_inst, 15));
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; BootAddr = '0; Stall = 1'b0; Halt = 1'b0;
        BranchEn = 1'b0; BranchRel = 1'b0; TargSel = '0; LutWe = 1'b0;
        LutWaddr = '0; LutWdata = '0;
        tick();
        tick();
        Reset = 1'b0;
        lit("rst_pc", int'(pc_a), m_pc, 0);
        lit("rst_run", int'(run_a), int'(m_state == 1), 0);
        lit("rst_done", int'(done_a), int'(m_state == 2), 0);
        lit("rst_cyc", int'(cyc_a), m_cyc, 0);

        // Preload table while idle
        LutWe = 1'b1; LutWaddr = 6'd3; LutWdata = 12'h200;
        tick();
        LutWaddr = 6'd4; LutWdata = 12'hFFE;
        tick();
        LutWe = 1'b0;
        lit("idle_pc", int'(pc_a), m_pc, 0);

        Start = 1'b1; BootAddr = 12'h010;
        tick();
        Start = 1'b0;
        lit("start_pc", int'(pc_a), m_pc, 'h010);
        lit("start_run", int'(run_a), int'(m_state == 1), 1);
        repeat (5) tick();
        lit("seq_pc", int'(pc_a), m_pc, 'h015);
        lit("seq_cyc", int'(cyc_a), m_cyc, 5);
        lit("seq_inst", int'(inst_a), m_inst, 5);

        BranchEn = 1'b1; BranchRel = 1'b0; TargSel = 6'd3;
        tick();
        lit("abs_pc", int'(pc_a), m_pc, 'h200);
        BranchRel = 1'b1; TargSel = 6'd4;
        tick();
        lit("rel_pc", int'(pc_a), m_pc, 'h1FE);
        BranchEn = 1'b0; BranchRel = 1'b0;

        Stall = 1'b1; Halt = 1'b1;
        repeat (3) tick();
        lit("stall_pc", int'(pc_a), m_pc, 'h1FE);
        lit("stall_inst", int'(inst_a), m_inst, 7);
        lit("stall_cyc", int'(cyc_a), m_cyc, 10);
        lit("stall_run", int'(run_a), int'(m_state == 1), 1);

        Stall = 1'b0;
        tick();
        Halt = 1'b0;
        lit("halt_done", int'(done_a), int'(m_state == 2), 1);
        lit("halt_run", int'(run_a), int'(m_state == 1), 0);
        lit("halt_pc", int'(pc_a), m_pc, 'h1FE);
        repeat (10) tick();
        lit("frz_cyc", int'(cyc_a), m_cyc, 11);
        lit("frz_inst", int'(inst_a), m_inst, 8);
        Start = 1'b1; BootAddr = 12'h000;
        tick();
        Start = 1'b0;
        lit("rest_pc", int'(pc_a), m_pc, 0);
        lit("rest_cyc", int'(cyc_a), m_cyc, 0);
        lit("rest_inst", int'(inst_a), m_inst, 0);

        Halt = 1'b1;
        tick();
        Halt = 1'b0; Start = 1'b1; BootAddr = 12'hFFE;
        tick();
        Start = 1'b0;
        lit("wrap_pc0", int'(pc_a), m_pc, 'hFFE);
        tick();
        lit("wrap_pc1", int'(pc_a), m_pc, 'hFFF);
        tick();
        lit("wrap_pc2", int'(pc_a), m_pc, 'h000);
        repeat (18) tick();
        lit("sat_pc", int'(pc_a), m_pc, 18);
        lit("sat_cyc_a", int'(cyc_a), m_cyc, 20);
        lit("sat_cyc_b", int'(cyc_b), sat(m_cyc, 15), 15);
        lit("sat_inst_b", int'(inst_b), sat(m_inst, 15), 15);

        Halt = 1'b1;
        tick();
        Halt = 1'b0; Start = 1'b1; BootAddr = 12'h123;
        tick();
        Start = 1'b0;
        lit("pre_rst_pc", int'(pc_a), m_pc, 'h123);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        lit("mid_rst_pc", int'(pc_a), m_pc, 0);
        lit("mid_rst_run", int'(run_a), int'(m_state == 1), 0);
        lit("mid_rst_cyc", int'(cyc_a), m_cyc, 0);
        Start = 1'b1; BootAddr = 12'h040;
        tick();
        Start = 1'b0;
        BranchEn = 1'b1; BranchRel = 1'b0; TargSel = 6'd3;
        tick();
        lit("cleared_tab", int'(pc_a), m_pc, 0);
        LutWe = 1'b1; LutWaddr = 6'd3; LutWdata = 12'h050;
        tick();
        LutWe = 1'b0;
        lit("wr_old_val", int'(pc_a), m_pc, 0);
        tick();
        lit("wr_new_val", int'(pc_a), m_pc, 'h050);
        BranchEn = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            Start     = ($urandom_range(0, 19) == 0);
            BootAddr  = PW'($urandom);
            Stall     = ($urandom_range(0, 3) == 0);
            Halt      = ($urandom_range(0, 29) == 0);
            BranchEn  = ($urandom_range(0, 5) == 0);
            BranchRel = $urandom_range(0, 1) == 1;
            TargSel   = LW'($urandom_range(0, 7));
            LutWe     = ($urandom_range(0, 4) == 0);
            LutWaddr  = LW'($urandom_range(0, 7));
            LutWdata  = PW'($urandom);
            tick();
        end

        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
